// File: rtl/serializer_pkg.sv
// Shared types and helpers for the bit serializer: FSM state encoding and
// bit-counter sizing.
package serializer_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  // A one-bit word still needs a one-bit counter, so clamp the width at 1.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out: a word is accepted via valid/ready and emitted one bit per clock.
// First bit one cycle after acceptance; a one-entry hold register keeps back-to-back words gapless.
module piso_bit_serializer
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             serial_first,
  output logic             serial_last,
  output logic             busy
);

  localparam int unsigned     CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic [WIDTH-1:0] hold_q;
  logic             hold_full_q;
  logic [CW-1:0]    cnt_q;
  logic             first_q;
  logic             accept;

  assign accept = in_valid && !hold_full_q;

  always_comb begin
    shift_d = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
      first_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          first_q <= 1'b0;
          if (accept) begin
            shift_q <= in_data;
            cnt_q   <= CNT_LAST;
            first_q <= 1'b1;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (cnt_q != '0) begin
            shift_q <= shift_d;
            cnt_q   <= cnt_q - 1'b1;
            first_q <= 1'b0;
            if (accept) begin
              hold_q      <= in_data;
              hold_full_q <= 1'b1;
            end
          end else if (hold_full_q) begin
            // Last bit going out: refill from the hold register without a bubble.
            shift_q     <= hold_q;
            hold_full_q <= 1'b0;
            cnt_q       <= CNT_LAST;
            first_q     <= 1'b1;
          end else if (accept) begin
            shift_q <= in_data;
            cnt_q   <= CNT_LAST;
            first_q <= 1'b1;
          end else begin
            first_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready     = !hold_full_q;
  assign serial_valid = (state_q == S_SHIFT);
  assign serial_first = first_q;
  assign serial_last  = serial_valid && (cnt_q == '0);
  assign serial_out   = serial_valid ? (MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0]) : IDLE_BIT;
  assign busy         = (state_q != S_IDLE) || hold_full_q;

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Directed bench for piso_bit_serializer: MSB-first, LSB-first and WIDTH=1 instances.
module tb_piso_bit_serializer;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic [7:0] in_data_m = '0, in_data_l = '0;
  logic [0:0] in_data_1 = '0;
  logic in_valid_m = 1'b0, in_valid_l = 1'b0, in_valid_1 = 1'b0;
  logic in_ready_m, so_m, sv_m, sf_m, sl_m, busy_m;
  logic in_ready_l, so_l, sv_l, sf_l, sl_l, busy_l;
  logic in_ready_1, so_1, sv_1, sf_1, sl_1, busy_1;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
    .clock(clock), .reset(reset), .in_data(in_data_m), .in_valid(in_valid_m),
    .in_ready(in_ready_m), .serial_out(so_m), .serial_valid(sv_m),
    .serial_first(sf_m), .serial_last(sl_m), .busy(busy_m));

  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
    .clock(clock), .reset(reset), .in_data(in_data_l), .in_valid(in_valid_l),
    .in_ready(in_ready_l), .serial_out(so_l), .serial_valid(sv_l),
    .serial_first(sf_l), .serial_last(sl_l), .busy(busy_l));

  piso_bit_serializer #(.WIDTH(1), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_1 (
    .clock(clock), .reset(reset), .in_data(in_data_1), .in_valid(in_valid_1),
    .in_ready(in_ready_1), .serial_out(so_1), .serial_valid(sv_1),
    .serial_first(sf_1), .serial_last(sl_1), .busy(busy_1));

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the MSB-first instance while it is mid-word.
  task automatic chk_m(input string tag, input logic exp_out, input logic exp_first,
                       input logic exp_last, input logic exp_ready);
    chk({tag, ".out"},   {7'd0, so_m},       {7'd0, exp_out});
    chk({tag, ".valid"}, {7'd0, sv_m},       8'd1);
    chk({tag, ".first"}, {7'd0, sf_m},       {7'd0, exp_first});
    chk({tag, ".last"},  {7'd0, sl_m},       {7'd0, exp_last});
    chk({tag, ".ready"}, {7'd0, in_ready_m}, {7'd0, exp_ready});
  endtask

  task automatic chk_m_idle(input string tag);
    chk({tag, ".valid"}, {7'd0, sv_m},       8'd0);
    chk({tag, ".out"},   {7'd0, so_m},       8'd0);
    chk({tag, ".first"}, {7'd0, sf_m},       8'd0);
    chk({tag, ".last"},  {7'd0, sl_m},       8'd0);
    chk({tag, ".ready"}, {7'd0, in_ready_m}, 8'd1);
    chk({tag, ".busy"},  {7'd0, busy_m},     8'd0);
  endtask

  initial begin
    logic [15:0] stream;
    logic [4:0]  window;
    logic [7:0]  lsb_exp;
    logic [7:0]  w2;
    logic [2:0]  w1_bits;

    // Reset state
    step();
    step();
    chk_m_idle("reset_m");
    chk("reset_l.valid", {7'd0, sv_l}, 8'd0);
    chk("reset_1.ready", {7'd0, in_ready_1}, 8'd1);
    reset = 1'b0;
    step();
    chk_m_idle("post_reset_m");

    // Single MSB-first word E8 -> 1,1,1,0,1,0,0,0
    in_valid_m = 1'b1;
    in_data_m  = 8'hE8;
    step();
    in_valid_m = 1'b0;
    in_data_m  = 8'h00;
    stream = {8'hE8, 8'h00};
    for (int k = 0; k < 8; k++) begin
      chk_m($sformatf("msb_b%0d", k + 1), stream[15 - k], k == 0, k == 7, 1'b1);
      chk($sformatf("msb_b%0d.busy", k + 1), {7'd0, busy_m}, 8'd1);
      step();
    end
    chk_m_idle("msb_after");

    // LSB-first word 1D -> 1,0,1,1,1,0,0,0
    in_valid_l = 1'b1;
    in_data_l  = 8'h1D;
    step();
    in_valid_l = 1'b0;
    lsb_exp = 8'b1011_1000;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("lsb_b%0d.out", k + 1), {7'd0, so_l}, {7'd0, lsb_exp[7 - k]});
      chk($sformatf("lsb_b%0d.valid", k + 1), {7'd0, sv_l}, 8'd1);
      chk($sformatf("lsb_b%0d.first", k + 1), {7'd0, sf_l}, {7'd0, k == 0});
      chk($sformatf("lsb_b%0d.last", k + 1), {7'd0, sl_l}, {7'd0, k == 7});
      step();
    end
    chk("lsb_after.valid", {7'd0, sv_l}, 8'd0);
    chk("lsb_after.out", {7'd0, so_l}, 8'd0);

    // Back-to-back E8 then FF with in_valid held
    in_valid_m = 1'b1;
    in_data_m  = 8'hE8;
    step();
    in_data_m = 8'hFF;
    stream = 16'hE8FF;
    window = '0;
    for (int k = 0; k < 16; k++) begin
      chk_m($sformatf("b2b_b%0d", k + 1), stream[15 - k], (k == 0) || (k == 8),
            (k == 7) || (k == 15), !((k >= 1) && (k <= 7)));
      window = {window[3:0], so_m};
      if (k == 4) chk("b2b_pattern_11101", {3'd0, window}, 8'h1D);
      step();
      if (k == 0) in_valid_m = 1'b0;
    end
    chk_m_idle("b2b_after");

    // Second word offered only during the last bit: loads directly, hold stays empty
    in_valid_m = 1'b1;
    in_data_m  = 8'hE8;
    step();
    in_valid_m = 1'b0;
    stream = 16'hE85A;
    for (int k = 0; k < 16; k++) begin
      chk_m($sformatf("direct_b%0d", k + 1), stream[15 - k], (k == 0) || (k == 8),
            (k == 7) || (k == 15), 1'b1);
      if (k == 7) begin
        in_valid_m = 1'b1;
        in_data_m  = 8'h5A;
      end
      step();
      in_valid_m = 1'b0;
    end
    chk_m_idle("direct_after");

    // Reset during bit 4 of E8, then 0F emits cleanly
    in_valid_m = 1'b1;
    in_data_m  = 8'hE8;
    step();
    in_valid_m = 1'b0;
    in_data_m  = 8'h33;
    step();
    step();
    step();
    chk_m("rst_mid_b4", 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_m_idle("rst_mid_after");
    step();
    chk_m_idle("rst_mid_settled");
    in_valid_m = 1'b1;
    in_data_m  = 8'h0F;
    step();
    in_valid_m = 1'b0;
    w2 = 8'h0F;
    for (int k = 0; k < 8; k++) begin
      chk_m($sformatf("post_rst_b%0d", k + 1), w2[7 - k], k == 0, k == 7, 1'b1);
      step();
    end
    chk_m_idle("post_rst_after");

    // WIDTH=1: words 1,0,1 back-to-back
    w1_bits = 3'b101;
    in_valid_1 = 1'b1;
    in_data_1  = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("w1_b%0d.out", k + 1), {7'd0, so_1}, {7'd0, w1_bits[2 - k]});
      chk($sformatf("w1_b%0d.valid", k + 1), {7'd0, sv_1}, 8'd1);
      chk($sformatf("w1_b%0d.first", k + 1), {7'd0, sf_1}, 8'd1);
      chk($sformatf("w1_b%0d.last", k + 1), {7'd0, sl_1}, 8'd1);
      chk($sformatf("w1_b%0d.ready", k + 1), {7'd0, in_ready_1}, 8'd1);
      if (k < 2) in_data_1 = w1_bits[1 - k];
      else in_valid_1 = 1'b0;
      step();
    end
    chk("w1_after.valid", {7'd0, sv_1}, 8'd0);
    chk("w1_after.out", {7'd0, so_1}, 8'd0);
    chk("w1_after.busy", {7'd0, busy_1}, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
